branch_hazard_stall_unit: RTL and testbench

ID-stage hazard controller for early (ID-resolved) branches. It works on the same operands the branch forwarding path serves.
- Decides when a branch in ID must wait because its source registers are not yet forwardable from MEM.
- Freezes PC and IF/ID, and inserts ID/EX bubbles, for the required number of cycles.
- Signals when the branch may resolve, and requests an IF flush on a taken branch.

---
 rtl/branch_hazard_stall_unit_pkg.sv | 22 ++
 rtl/branch_hazard_stall_unit_dep_cost.sv | 39 +++
 rtl/branch_hazard_stall_unit.sv | 121 ++++++++++++
 tb/tb_branch_hazard_stall_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/branch_hazard_stall_unit_pkg.sv
// Shared constants for the ID-stage branch hazard controller: FSM encoding
// and per-producer stall costs.
package branch_hazard_stall_unit_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam int COST_W = 2;

   localparam logic [COST_W-1:0] STALL_NONE     = 2'd0;
   localparam logic [COST_W-1:0] STALL_EX_LOAD  = 2'd2;
   localparam logic [COST_W-1:0] STALL_EX_ALU   = 2'd1;
   localparam logic [COST_W-1:0] STALL_MEM_LOAD = 2'd1;

   function automatic logic [COST_W-1:0] cost_max(input logic [COST_W-1:0] a,
                                                  input logic [COST_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/branch_hazard_stall_unit_dep_cost.sv
// Stall cost of one branch source register against the EX and MEM producers.
// A WB producer never costs anything because the register file writes before it reads.
module branch_dep_cost
   import branch_hazard_stall_unit_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              i_check,
   input  logic [REG_AW-1:0] i_src,
   input  logic [REG_AW-1:0] i_ex_rw,
   input  logic              i_ex_regwr,
   input  logic              i_ex_memtoreg,
   input  logic [REG_AW-1:0] i_mem_rw,
   input  logic              i_mem_regwr,
   input  logic              i_mem_memtoreg,
   output logic [COST_W-1:0] o_cost
);

   logic w_ex_match;
   logic w_mem_match;
   logic [COST_W-1:0] w_ex_cost;
   logic [COST_W-1:0] w_mem_cost;

   // Register 0 is hardwired, so a producer targeting it is never a dependence.
   assign w_ex_match  = i_check && i_ex_regwr  && (i_ex_rw  != '0) && (i_ex_rw  == i_src);
   assign w_mem_match = i_check && i_mem_regwr && (i_mem_rw != '0) && (i_mem_rw == i_src);

   always_comb begin
      w_ex_cost  = STALL_NONE;
      w_mem_cost = STALL_NONE;
      if (w_ex_match)
         w_ex_cost = i_ex_memtoreg ? STALL_EX_LOAD : STALL_EX_ALU;
      if (w_mem_match && i_mem_memtoreg)
         w_mem_cost = STALL_MEM_LOAD;
   end

   assign o_cost = cost_max(w_ex_cost, w_mem_cost);

endmodule

// File: rtl/branch_hazard_stall_unit.sv
// ID-stage stall controller for ID-resolved branches: freezes PC/IF-ID and
// bubbles ID/EX until both branch operands are forwardable from MEM or the regfile.
module branch_hazard_stall_unit
   import branch_hazard_stall_unit_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ID_Branch,
   input  logic              ID_BranchTaken,
   input  logic [REG_AW-1:0] ID_Ra,
   input  logic [REG_AW-1:0] ID_Rb,
   input  logic [REG_AW-1:0] EX_Rw,
   input  logic              EX_RegWr,
   input  logic              EX_MemtoReg,
   input  logic [REG_AW-1:0] Mem_Rw,
   input  logic              Mem_RegWr,
   input  logic              Mem_MemtoReg,
   output logic              PC_Write,
   output logic              IFID_Write,
   output logic              IDEX_Bubble,
   output logic              BranchReady,
   output logic              IF_Flush,
   output logic [CNT_W-1:0]  StallCnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [COST_W-1:0] w_cost_a;
   logic [COST_W-1:0] w_cost_b;
   logic [COST_W-1:0] w_need;
   logic [COST_W-1:0] w_need_m1;

   branch_dep_cost #(.REG_AW(REG_AW)) u_cost_a (
      .i_check        (ID_Branch),
      .i_src          (ID_Ra),
      .i_ex_rw        (EX_Rw),
      .i_ex_regwr     (EX_RegWr),
      .i_ex_memtoreg  (EX_MemtoReg),
      .i_mem_rw       (Mem_Rw),
      .i_mem_regwr    (Mem_RegWr),
      .i_mem_memtoreg (Mem_MemtoReg),
      .o_cost         (w_cost_a)
   );

   branch_dep_cost #(.REG_AW(REG_AW)) u_cost_b (
      .i_check        (ID_Branch),
      .i_src          (ID_Rb),
      .i_ex_rw        (EX_Rw),
      .i_ex_regwr     (EX_RegWr),
      .i_ex_memtoreg  (EX_MemtoReg),
      .i_mem_rw       (Mem_Rw),
      .i_mem_regwr    (Mem_RegWr),
      .i_mem_memtoreg (Mem_MemtoReg),
      .o_cost         (w_cost_b)
   );

   assign w_need    = cost_max(w_cost_a, w_cost_b);
   assign w_need_m1 = w_need - 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      PC_Write    = 1'b1;
      IFID_Write  = 1'b1;
      IDEX_Bubble = 1'b0;
      BranchReady = 1'b0;
      StallCnt    = '0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               if (w_need == STALL_NONE) begin
                  BranchReady = ID_Branch;
               end else begin
                  PC_Write    = 1'b0;
                  IFID_Write  = 1'b0;
                  IDEX_Bubble = 1'b1;
                  StallCnt    = CNT_W'(w_need_m1);
                  // A one-cycle need is re-evaluated from IDLE next cycle instead of holding.
                  if (w_need > 2'd1) begin
                     w_state_nxt = ST_HOLD;
                     w_cnt_nxt   = CNT_W'(w_need_m1);
                  end
               end
            end
            ST_HOLD: begin
               PC_Write    = 1'b0;
               IFID_Write  = 1'b0;
               IDEX_Bubble = 1'b1;
               StallCnt    = r_cnt - CNT_ONE;
               w_cnt_nxt   = r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE)
                  w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign IF_Flush = BranchReady & ID_BranchTaken;

endmodule

// File: tb/tb_branch_hazard_stall_unit.sv
// Directed-vector bench for branch_hazard_stall_unit with hand-computed expectations.
module tb_branch_hazard_stall_unit;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 2;

   logic              clk;
   logic              rst;
   logic              ID_Branch;
   logic              ID_BranchTaken;
   logic [REG_AW-1:0] ID_Ra;
   logic [REG_AW-1:0] ID_Rb;
   logic [REG_AW-1:0] EX_Rw;
   logic              EX_RegWr;
   logic              EX_MemtoReg;
   logic [REG_AW-1:0] Mem_Rw;
   logic              Mem_RegWr;
   logic              Mem_MemtoReg;
   logic              PC_Write;
   logic              IFID_Write;
   logic              IDEX_Bubble;
   logic              BranchReady;
   logic              IF_Flush;
   logic [CNT_W-1:0]  StallCnt;

   int n_checks;
   int n_fail;

   branch_hazard_stall_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .ID_Branch      (ID_Branch),
      .ID_BranchTaken (ID_BranchTaken),
      .ID_Ra          (ID_Ra),
      .ID_Rb          (ID_Rb),
      .EX_Rw          (EX_Rw),
      .EX_RegWr       (EX_RegWr),
      .EX_MemtoReg    (EX_MemtoReg),
      .Mem_Rw         (Mem_Rw),
      .Mem_RegWr      (Mem_RegWr),
      .Mem_MemtoReg   (Mem_MemtoReg),
      .PC_Write       (PC_Write),
      .IFID_Write     (IFID_Write),
      .IDEX_Bubble    (IDEX_Bubble),
      .BranchReady    (BranchReady),
      .IF_Flush       (IF_Flush),
      .StallCnt       (StallCnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs are driven 1 time unit after posedge; outputs sampled mid-cycle.
   task automatic expect_out(input string tag, input int pc, input int ifid, input int bub,
                             input int rdy, input int flush, input int cnt);
      #3;
      check_eq({tag, ".PC_Write"},    int'(PC_Write),    pc);
      check_eq({tag, ".IFID_Write"},  int'(IFID_Write),  ifid);
      check_eq({tag, ".IDEX_Bubble"}, int'(IDEX_Bubble), bub);
      check_eq({tag, ".BranchReady"}, int'(BranchReady), rdy);
      check_eq({tag, ".IF_Flush"},    int'(IF_Flush),    flush);
      check_eq({tag, ".StallCnt"},    int'(StallCnt),    cnt);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ID_Branch = 0; ID_BranchTaken = 0; ID_Ra = 0; ID_Rb = 0;
      EX_Rw = 0; EX_RegWr = 0; EX_MemtoReg = 0;
      Mem_Rw = 0; Mem_RegWr = 0; Mem_MemtoReg = 0;
   endtask

   task automatic drive_branch(input int ra, input int rb, input int taken);
      ID_Branch = 1; ID_Ra = REG_AW'(ra); ID_Rb = REG_AW'(rb); ID_BranchTaken = taken[0];
   endtask

   task automatic drive_ex(input int rw, input int wr, input int ld);
      EX_Rw = REG_AW'(rw); EX_RegWr = wr[0]; EX_MemtoReg = ld[0];
   endtask

   task automatic drive_mem(input int rw, input int wr, input int ld);
      Mem_Rw = REG_AW'(rw); Mem_RegWr = wr[0]; Mem_MemtoReg = ld[0];
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear_inputs();
      rst = 1;
      // Reset with a live EX-load hazard must still show reset outputs.
      drive_branch(3, 4, 1);
      drive_ex(3, 1, 1);
      #1;
      expect_out("reset", 1, 1, 0, 0, 0, 0);
      next_cycle();
      rst = 0;
      clear_inputs();

      // No dependence, taken and not taken
      drive_branch(3, 4, 1); drive_ex(5, 1, 0); drive_mem(6, 1, 0);
      expect_out("nodep_taken", 1, 1, 0, 1, 1, 0);
      next_cycle();
      ID_BranchTaken = 0;
      expect_out("nodep_nt", 1, 1, 0, 1, 0, 0);
      next_cycle(); clear_inputs();

      // MEM ALU producer forwarded: no stall
      drive_branch(3, 7, 1); drive_mem(3, 1, 0);
      expect_out("mem_alu", 1, 1, 0, 1, 1, 0);
      next_cycle(); clear_inputs();

      // EX ALU producer: one stall, then producer in MEM
      drive_branch(3, 4, 0); drive_ex(4, 1, 0);
      expect_out("ex_alu_s0", 0, 0, 1, 0, 0, 0);
      next_cycle();
      drive_ex(0, 0, 0); drive_mem(4, 1, 0);
      expect_out("ex_alu_rdy", 1, 1, 0, 1, 0, 0);
      next_cycle(); clear_inputs();

      // EX load producer: two stalls, flush suppressed, then ready
      drive_branch(3, 9, 1); drive_ex(3, 1, 1);
      expect_out("ex_ld_s0", 0, 0, 1, 0, 0, 1);
      next_cycle();
      drive_ex(0, 0, 0); drive_mem(3, 1, 1);
      expect_out("ex_ld_s1", 0, 0, 1, 0, 0, 0);
      next_cycle();
      drive_mem(0, 0, 0);
      expect_out("ex_ld_rdy", 1, 1, 0, 1, 1, 0);
      next_cycle(); clear_inputs();

      // Register zero never matches
      drive_branch(0, 0, 1); drive_ex(0, 1, 1); drive_mem(0, 1, 1);
      expect_out("zero_reg", 1, 1, 0, 1, 1, 0);
      next_cycle(); clear_inputs();

      // RegWr=0 producer never matches
      drive_branch(3, 3, 0); drive_ex(3, 0, 1); drive_mem(3, 0, 1);
      expect_out("no_regwr", 1, 1, 0, 1, 0, 0);
      next_cycle(); clear_inputs();

      // Mixed: Ra MEM load (1), Rb EX load (2) -> max 2
      drive_branch(3, 4, 1); drive_mem(3, 1, 1); drive_ex(4, 1, 1);
      expect_out("mixed_s0", 0, 0, 1, 0, 0, 1);
      next_cycle();
      expect_out("mixed_s1", 0, 0, 1, 0, 0, 0);
      next_cycle();
      drive_ex(0, 0, 0); drive_mem(0, 0, 0);
      expect_out("mixed_rdy", 1, 1, 0, 1, 1, 0);
      next_cycle(); clear_inputs();

      // MEM load: one stall, re-evaluated from IDLE
      drive_branch(5, 6, 0); drive_mem(5, 1, 1);
      expect_out("mem_ld_s0", 0, 0, 1, 0, 0, 0);
      next_cycle();
      drive_mem(0, 0, 0);
      expect_out("mem_ld_rdy", 1, 1, 0, 1, 0, 0);
      next_cycle(); clear_inputs();

      // Non-branch never stalls
      ID_Branch = 0; ID_BranchTaken = 1; ID_Ra = 3; drive_ex(3, 1, 1);
      expect_out("non_branch", 1, 1, 0, 0, 0, 0);
      next_cycle(); clear_inputs();

      // Reset asserted mid-HOLD
      drive_branch(3, 4, 1); drive_ex(3, 1, 1);
      expect_out("rst_hold_s0", 0, 0, 1, 0, 0, 1);
      next_cycle();
      rst = 1;
      expect_out("rst_in_hold", 1, 1, 0, 0, 0, 0);
      next_cycle();
      rst = 0;
      drive_ex(0, 0, 0);
      expect_out("rst_after", 1, 1, 0, 1, 1, 0);
      next_cycle(); clear_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
